countdown_timer: RTL and testbench
==================================

// Module: countdown_timer
// PURPOSE
//   Loadable down-counter with terminal-count detection: the decrementing
//   counterpart to the incrementing PC/address counter. Loaded from the data
//   bus, it counts down one per enabled tick and raises a sticky pending flag
//   on expiry. Optional auto-reload makes it a periodic timer. Used for delay
//   loops and periodic tick generation next to the PC counter.
// PARAMETERS
//   WordSize  16  width of data, count and reload registers
// PORTS
//   clk     in   1         clock; all state changes on posedge
//   reset   in   1         synchronous reset, active-high
//   LE      in   1         load count + reload reg from data, active low
//   DE      in   1         decrement enable (tick), active low
//   CLR     in   1         clear pend and ovf, active low
//   AR      in   1         auto-reload mode, active high; sampled at terminal tick
//   data    in   WordSize  load value
//   result  out  WordSize  current count (registered)
//   zero    out  1         result==0 (combinational from result)
//   busy    out  1         1 when state==RUN
//   pend    out  1         sticky terminal-count flag
//   ovf     out  1         sticky: terminal tick while pend already 1
// BEHAVIOUR
//   - Reset (reset==1 at posedge): result=0, reload=0, pend=0, ovf=0,
//     state=IDLE. Overrides all other inputs, including mid-count.
//   - States: IDLE (never loaded / loaded 0), RUN (counting), DONE (expired).
//   - Priority within a cycle: reset > LE > DE. CLR is independent of LE/DE.
//   - LE==0 in any state: result<=data, reload<=data. Next state is RUN if
//     data!=0, else IDLE. pend/ovf unchanged. Any DE that cycle is ignored.
//   - IDLE, DONE: DE ignored; result holds.
//   - RUN, DE==0, result>1: result<=result-1, stay RUN.
//   - RUN, DE==0, result==1 (terminal tick):
//       pend<=1; if pend already 1 (and not cleared that cycle), ovf<=1.
//       AR==1: result<=reload, stay RUN (result never shows 0 in this mode).
//       AR==0: result<=0, state<=DONE.
//   - RUN, DE==1: result holds.
//   - Latency: one clock from strobe to updated result/pend/busy.
//   - CLR==0: pend<=0 and ovf<=0, except a terminal tick in the same cycle
//     wins: pend=1, ovf=0 (set beats clear; the prior pend counts as acked).
//   - Arithmetic: unsigned, modulo 2**WordSize. result==0 is unreachable in
//     RUN, so there is no underflow. Load of all-ones is legal (max period).
//   - Reload reg is written only by LE; AR changes mid-count take effect at
//     the next terminal tick.
// TESTING
//   1. reset=1, then load 5, DE=0 x2 -> result 3; reset=1 one cycle ->
//      result 0, busy 0, pend 0, ovf 0, zero 1.
//   2. load 3, AR=0, DE=0 x3 -> result 2,1,0; pend=1 and busy=0 after 3rd
//      tick; further DE=0 ticks -> result stays 0.
//   3. load 2, AR=1, DE=0 x4 -> result 1,2,1,2; pend=1 after tick 2;
//      ovf=1 after tick 4; busy stays 1.
//   4. AR=1, pend=1, CLR=0 in the same cycle as a terminal tick ->
//      pend=1, ovf=0.
//   5. LE=0 and DE=0 same cycle with data=7 -> result 7, not 6;
//      load data=0 -> state IDLE, zero 1, busy 0, DE ignored.
//   6. RUN with count 4, DE=1 for 10 cycles -> result holds 4;
//      LE=0 data=9 mid-count -> result 9, busy 1.

Source files
------------

// File: rtl/countdown_timer_if.sv
// rtl/countdown_timer_if.sv - control/status bundle between a timer user (master) and countdown_timer (slave)
interface countdown_timer_if #(
  parameter int WordSize = 16
);
  logic                LE;
  logic                DE;
  logic                CLR;
  logic                AR;
  logic [WordSize-1:0] data;
  logic [WordSize-1:0] result;
  logic                zero;
  logic                busy;
  logic                pend;
  logic                ovf;

  modport master (
    output LE, DE, CLR, AR, data,
    input  result, zero, busy, pend, ovf
  );

  modport slave (
    input  LE, DE, CLR, AR, data,
    output result, zero, busy, pend, ovf
  );
endinterface

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - loadable down-counter with sticky terminal-count flag and optional auto-reload
module countdown_timer #(
  parameter int WordSize = 16
) (
  input  logic               clk,
  input  logic               reset,
  countdown_timer_if.slave   bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state, state_next;
  logic [WordSize-1:0] count, count_next;
  logic [WordSize-1:0] reload, reload_next;
  logic                pend, pend_next;
  logic                ovf, ovf_next;

  logic load;
  logic tick;
  logic terminal;

  assign load     = !bus.LE;
  assign tick     = !load && (state == RUN) && !bus.DE;
  assign terminal = tick && (count == WordSize'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
      pend   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      state  <= state_next;
      count  <= count_next;
      reload <= reload_next;
      pend   <= pend_next;
      ovf    <= ovf_next;
    end
  end

  always_comb begin
    state_next  = state;
    count_next  = count;
    reload_next = reload;
    pend_next   = pend;
    ovf_next    = ovf;

    if (load) begin
      count_next  = bus.data;
      reload_next = bus.data;
      state_next  = (bus.data != '0) ? RUN : IDLE;
    end else if (tick) begin
      if (terminal) begin
        if (bus.AR) begin
          count_next = reload;
        end else begin
          count_next = '0;
          state_next = DONE;
        end
      end else begin
        count_next = count - WordSize'(1);
      end
    end

    // A terminal tick beats a same-cycle clear; the old pend is treated as acknowledged.
    if (terminal) begin
      pend_next = 1'b1;
      ovf_next  = bus.CLR ? (ovf | pend) : 1'b0;
    end else if (!bus.CLR) begin
      pend_next = 1'b0;
      ovf_next  = 1'b0;
    end
  end

  assign bus.result = count;
  assign bus.zero   = (count == '0);
  assign bus.busy   = (state == RUN);
  assign bus.pend   = pend;
  assign bus.ovf    = ovf;
endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - directed self-checking bench for countdown_timer
module tb_countdown_timer;
  localparam int W = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  countdown_timer_if #(.WordSize(W)) bus ();

  countdown_timer #(.WordSize(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of strobes, clock it, sample 1ns after the edge.
  task automatic step(input logic le, input logic de, input logic clr,
                      input logic ar, input logic [W-1:0] d);
    bus.LE   = le;
    bus.DE   = de;
    bus.CLR  = clr;
    bus.AR   = ar;
    bus.data = d;
    @(posedge clk);
    #1;
    bus.LE  = 1'b1;
    bus.DE  = 1'b1;
    bus.CLR = 1'b1;
  endtask

  task automatic chk_status(input string tag, input logic [W-1:0] r, input logic z,
                            input logic b, input logic p, input logic o);
    chk({tag, ".result"}, 32'(bus.result), 32'(r));
    chk({tag, ".zero"},   32'(bus.zero),   32'(z));
    chk({tag, ".busy"},   32'(bus.busy),   32'(b));
    chk({tag, ".pend"},   32'(bus.pend),   32'(p));
    chk({tag, ".ovf"},    32'(bus.ovf),    32'(o));
  endtask

  initial begin
    bus.LE = 1'b1; bus.DE = 1'b1; bus.CLR = 1'b1; bus.AR = 1'b0; bus.data = '0;

    // 1: reset, count a bit, reset mid-count
    reset = 1'b1;
    step(1, 1, 1, 0, 16'd0);
    chk_status("rst0", 16'd0, 1, 0, 0, 0);
    reset = 1'b0;
    step(0, 1, 1, 0, 16'd5);
    chk_status("load5", 16'd5, 0, 1, 0, 0);
    step(1, 0, 1, 0, 16'd0);
    step(1, 0, 1, 0, 16'd0);
    chk("dec5x2", 32'(bus.result), 32'd3);
    reset = 1'b1;
    step(0, 0, 0, 0, 16'd8);
    chk_status("rst_mid", 16'd0, 1, 0, 0, 0);
    reset = 1'b0;

    // 2: one-shot expiry
    step(0, 1, 1, 0, 16'd3);
    chk("load3", 32'(bus.result), 32'd3);
    step(1, 0, 1, 0, 16'd0);
    chk("os_t1", 32'(bus.result), 32'd2);
    step(1, 0, 1, 0, 16'd0);
    chk_status("os_t2", 16'd1, 0, 1, 0, 0);
    step(1, 0, 1, 0, 16'd0);
    chk_status("os_t3", 16'd0, 1, 0, 1, 0);
    step(1, 0, 1, 0, 16'd0);
    chk_status("os_after", 16'd0, 1, 0, 1, 0);
    step(1, 1, 0, 0, 16'd0);
    chk_status("clr", 16'd0, 1, 0, 0, 0);

    // 3: auto-reload, overflow on second expiry
    step(0, 1, 1, 1, 16'd2);
    chk("load2", 32'(bus.result), 32'd2);
    step(1, 0, 1, 1, 16'd0);
    chk_status("ar_t1", 16'd1, 0, 1, 0, 0);
    step(1, 0, 1, 1, 16'd0);
    chk_status("ar_t2", 16'd2, 0, 1, 1, 0);
    step(1, 0, 1, 1, 16'd0);
    chk_status("ar_t3", 16'd1, 0, 1, 1, 0);
    step(1, 0, 1, 1, 16'd0);
    chk_status("ar_t4", 16'd2, 0, 1, 1, 1);

    // 4: clear coincident with terminal tick -> set wins, ovf cleared
    step(1, 0, 1, 1, 16'd0);
    chk("ar_t5", 32'(bus.result), 32'd1);
    step(1, 0, 0, 1, 16'd0);
    chk_status("clr_term", 16'd2, 0, 1, 1, 0);
    step(1, 1, 0, 1, 16'd0);
    chk_status("clr_idle_tick", 16'd2, 0, 1, 0, 0);

    // 5: load beats decrement; load of zero parks in IDLE
    step(0, 0, 1, 0, 16'd7);
    chk_status("le_de", 16'd7, 0, 1, 0, 0);
    step(0, 1, 1, 0, 16'd0);
    chk_status("load0", 16'd0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 16'd0);
    chk_status("idle_de", 16'd0, 1, 0, 0, 0);

    // 6: hold with DE inactive, reload mid-count
    step(0, 1, 1, 0, 16'd4);
    for (int i = 0; i < 10; i++) step(1, 1, 1, 0, 16'd0);
    chk_status("hold4", 16'd4, 0, 1, 0, 0);
    step(0, 1, 1, 0, 16'd9);
    chk_status("reload9", 16'd9, 0, 1, 0, 0);

    // max-period load and an AR change taking effect at the next terminal tick
    step(0, 1, 1, 0, 16'hFFFF);
    step(1, 0, 1, 0, 16'd0);
    chk("max_dec", 32'(bus.result), 32'hFFFE);
    step(0, 1, 1, 0, 16'd2);
    step(1, 0, 1, 0, 16'd0);
    chk("ar_late_t1", 32'(bus.result), 32'd1);
    step(1, 0, 1, 1, 16'd0);
    chk_status("ar_late_t2", 16'd2, 0, 1, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
